// File: rtl/param_ram_clr_pkg.sv
// Shared types and constants for the parametrised clearable RAM.
package param_ram_clr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    function automatic logic adr_in_range(input int adr, input int depth);
        return adr < depth;
    endfunction

endpackage

// File: rtl/param_ram_clr_if.sv
// User-side request/response bundle of the clearable RAM.
interface param_ram_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 3
);
    logic              clr;
    logic              w;
    logic              rd_req;
    logic [ADR_W-1:0]  data_adr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;

    modport master (
        output clr, w, rd_req, data_adr, data_in,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  clr, w, rd_req, data_adr, data_in,
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/param_ram_clr_clear_fsm.sv
// Clear sequencer: walks the array writing zero, one word per cycle.
// Latency: sweep lasts exactly DEPTH cycles after reset release or accepted clr.
// Backpressure: none; clr is only honoured while idle.
module param_ram_clr_clear_fsm
    import param_ram_clr_pkg::*;
#(
    parameter int ADR_W = 3,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             busy,
    output logic             clr_we,
    output logic [ADR_W-1:0] clr_adr
);

    state_e           state_q, state_d;
    logic [ADR_W-1:0] clr_ptr_q, clr_ptr_d;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == ADR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign busy    = (state_q == ST_CLEAR);
    assign clr_we  = busy;
    assign clr_adr = clr_ptr_q;

endmodule

// File: rtl/param_ram_clr.sv
// Single-port RAM with self-clearing sweep and read-valid strobe.
// Latency: read data 1 cycle after rd_req (2 with OUT_REG=1), fully pipelined.
// Backpressure: none; w/rd_req/clr are silently ignored while busy.
module param_ram_clr
    import param_ram_clr_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADR_W   = 3,
    parameter int DEPTH   = 2 ** ADR_W,
    parameter int RD_MODE = RD_FIRST,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    param_ram_clr_if.slave bus
);

    logic             busy;
    logic             clr_we;
    logic [ADR_W-1:0] clr_adr;

    param_ram_clr_clear_fsm #(
        .ADR_W (ADR_W),
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_adr (clr_adr)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic              usr_we;
    logic              usr_rd;
    logic [DATA_W-1:0] rd_word;

    assign in_range = adr_in_range(int'(bus.data_adr), DEPTH);
    assign usr_we   = !busy && bus.w && in_range;
    assign usr_rd   = !busy && bus.rd_req;

    // No reset on the array so it can map onto block RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_adr] <= '0;
        end else if (usr_we) begin
            mem[bus.data_adr] <= bus.data_in;
        end
    end

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = (RD_MODE == WR_FIRST && bus.w) ? bus.data_in : mem[bus.data_adr];
        end
    end

    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] rd_dat_q, rd_dat_d;

    always_comb begin
        rd_vld_d = usr_rd;
        rd_dat_d = usr_rd ? rd_word : rd_dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              out_vld_q;
            logic [DATA_W-1:0] out_dat_q, out_dat_d;

            assign out_dat_d = rd_vld_q ? rd_dat_q : out_dat_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld_q <= 1'b0;
                    out_dat_q <= '0;
                end else begin
                    out_vld_q <= rd_vld_q;
                    out_dat_q <= out_dat_d;
                end
            end

            assign bus.rd_valid = out_vld_q;
            assign bus.data_out = out_dat_q;
        end else begin : g_noreg
            assign bus.rd_valid = rd_vld_q;
            assign bus.data_out = rd_dat_q;
        end
    endgenerate

    assign bus.busy = busy;

endmodule

// File: tb/tb_param_ram_clr.sv
// Three RAM configurations driven in lockstep and checked every cycle against a word-array model.
module tb_param_ram_clr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    param_ram_clr_if #(.DATA_W(8), .ADR_W(3)) bus0 ();
    param_ram_clr_if #(.DATA_W(8), .ADR_W(3)) bus1 ();
    param_ram_clr_if #(.DATA_W(8), .ADR_W(3)) bus2 ();

    param_ram_clr #(.DATA_W(8), .ADR_W(3), .DEPTH(8), .RD_MODE(0), .OUT_REG(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    param_ram_clr #(.DATA_W(8), .ADR_W(3), .DEPTH(8), .RD_MODE(1), .OUT_REG(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    param_ram_clr #(.DATA_W(8), .ADR_W(3), .DEPTH(6), .RD_MODE(0), .OUT_REG(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int dep[3];
    int rdm[3];
    int lat[3];

    logic [7:0] mem_m [3][8];
    int         sweep_left[3];
    logic       exp_vld[3];
    logic [7:0] exp_dat[3];
    logic       exp_busy[3];
    logic       obs_vld[3];
    logic [7:0] obs_dat[3];
    logic       obs_busy[3];

    typedef struct {
        int         inst;
        int         due;
        logic [7:0] d;
    } rd_t;
    rd_t pq[$];

    int cyc;
    int total;
    int bad;

    task automatic drive(input logic c, input logic wv, input logic r,
                         input logic [2:0] a, input logic [7:0] d);
        bus0.clr = c; bus0.w = wv; bus0.rd_req = r; bus0.data_adr = a; bus0.data_in = d;
        bus1.clr = c; bus1.w = wv; bus1.rd_req = r; bus1.data_adr = a; bus1.data_in = d;
        bus2.clr = c; bus2.w = wv; bus2.rd_req = r; bus2.data_adr = a; bus2.data_in = d;
    endtask

    task automatic sample();
        obs_vld[0] = bus0.rd_valid; obs_dat[0] = bus0.data_out; obs_busy[0] = bus0.busy;
        obs_vld[1] = bus1.rd_valid; obs_dat[1] = bus1.data_out; obs_busy[1] = bus1.busy;
        obs_vld[2] = bus2.rd_valid; obs_dat[2] = bus2.data_out; obs_busy[2] = bus2.busy;
    endtask

    // One clock of stimulus; the model applies the behavioural rules for that edge.
    task automatic step(input logic c, input logic wv, input logic r,
                        input logic [2:0] a, input logic [7:0] d);
        rd_t e;
        drive(c, wv, r, a, d);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (sweep_left[k] > 0) begin
                mem_m[k][dep[k] - sweep_left[k]] = 8'h00;
                sweep_left[k]--;
            end else begin
                if (r) begin
                    e.inst = k;
                    e.due  = cyc + lat[k] - 1;
                    if (int'(a) >= dep[k])   e.d = 8'h00;
                    else if (rdm[k] == 1 && wv) e.d = d;
                    else                      e.d = mem_m[k][a];
                    pq.push_back(e);
                end
                if (wv && int'(a) < dep[k]) mem_m[k][a] = d;
                if (c) sweep_left[k] = dep[k];
            end
            exp_vld[k] = 1'b0;
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].due == cyc) begin
                exp_vld[pq[i].inst] = 1'b1;
                exp_dat[pq[i].inst] = pq[i].d;
                pq.delete(i);
            end
        end
        for (int k = 0; k < 3; k++) exp_busy[k] = (sweep_left[k] > 0);
        @(posedge clk);
        #1;
        sample();
    endtask

    // Asserts rst mid-cycle, samples before any edge, releases after one edge.
    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        #2 rst = 1'b1;
        pq.delete();
        for (int k = 0; k < 3; k++) begin
            exp_vld[k]    = 1'b0;
            exp_dat[k]    = 8'h00;
            exp_busy[k]   = 1'b1;
            sweep_left[k] = dep[k];
        end
        #1 sample();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                bad++;
                $display("FAIL reset_async dut%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                         k, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
            end
        end
        release_reset();
        for (int n = 0; n < 20; n++) begin
            if (n < 10) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            else        step(1'b0, 1'b0, (n < 18), 3'(n - 10), 8'h00);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL reset_sweep dut%0d cyc=%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        for (int n = 0; n < 5; n++) begin
            if (n == 0)      step(1'b0, 1'b1, 1'b0, 3'd3, 8'hA5);
            else if (n == 1) step(1'b0, 1'b0, 1'b1, 3'd3, 8'h00);
            else             step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL write_read dut%0d cyc=%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_rw_same();
        for (int n = 0; n < 6; n++) begin
            if (n == 0)      step(1'b0, 1'b1, 1'b0, 3'd5, 8'h11);
            else if (n == 1) step(1'b0, 1'b1, 1'b1, 3'd5, 8'h22);
            else if (n == 2) step(1'b0, 1'b0, 1'b1, 3'd5, 8'h00);
            else             step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL rw_same dut%0d cyc=%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_clear();
        for (int n = 0; n < 30; n++) begin
            if (n < 8)       step(1'b0, 1'b1, 1'b0, 3'(n), 8'hFF);
            else if (n == 8) step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
            else if (n == 10) step(1'b1, 1'b1, 1'b1, 3'd2, 8'h77);
            else if (n < 19) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            else             step(1'b0, 1'b0, (n < 27), 3'(n - 19), 8'h00);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL clear dut%0d cyc=%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        step(1'b0, 1'b1, 1'b0, 3'd1, 8'h5C);
        step(1'b0, 1'b0, 1'b1, 3'd1, 8'h00);
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                bad++;
                $display("FAIL abort_inflight dut%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                         k, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
            end
        end
        release_reset();
        for (int n = 0; n < 10; n++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 3'd6, 8'h99);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                bad++;
                $display("FAIL abort_sweep dut%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                         k, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
            end
        end
        release_reset();
        for (int n = 0; n < 20; n++) begin
            if (n < 10) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            else        step(1'b0, 1'b0, (n < 18), 3'(n - 10), 8'h00);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL abort_resweep dut%0d cyc=%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            if (n < 6)      step(1'b0, 1'b1, 1'b0, 3'(n + 2), 8'(8'h30 + n));
            else if (n < 14) step(1'b0, 1'b0, 1'b1, 3'(n - 6), 8'h00);
            else            step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL back_to_back dut%0d cyc=%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic       c, wv, r;
        logic [2:0] a;
        logic [7:0] d;
        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 39) == 0);
            wv = $urandom_range(0, 1);
            r  = $urandom_range(0, 1);
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            step(c, wv, r, a, d);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_vld[k] !== exp_vld[k] || obs_dat[k] !== exp_dat[k] || obs_busy[k] !== exp_busy[k]) begin
                    bad++;
                    $display("FAIL random dut%0d cyc=%0d got vld=%b dat=%h busy=%b want vld=%b dat=%h busy=%b",
                             k, cyc, obs_vld[k], obs_dat[k], obs_busy[k], exp_vld[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
    endtask

    initial begin
        dep = '{8, 8, 6};
        rdm = '{0, 1, 0};
        lat = '{1, 2, 2};
        cyc   = 0;
        total = 0;
        bad   = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) mem_m[k][i] = 8'h00;
            sweep_left[k] = 0;
            exp_dat[k]    = 8'h00;
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);

        test_reset();
        test_write_read();
        test_rw_same();
        test_clear();
        test_reset_abort();
        test_back_to_back();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
